tdm_voice_scheduler: RTL
========================

// Module: tdm_voice_scheduler
// PURPOSE
//  Sequences the TDM pipeline: drives a free-running voice slot counter, one slot per sys_clk.
//  Owns the voice table: per voice, an active bit, a note number and an age.
//  Accepts note-on/off requests over a valid/ready handshake and allocates voices, stealing the oldest when all are busy.
//  Sits upstream of TDM_PIPELINE. Its slot and enable outputs drive TDM_CHANNEL_NUM/TDM_CHANNEL_IS_EN.
// PARAMETERS
//  NUM_VOICES  4  voices = TDM slots per frame (power of 2)
//  VOICE_BITS  2  log2(NUM_VOICES)
//  NOTE_W      7  note number width (MIDI)
//  AGE_W       4  per-voice age counter width, saturating
// PORTS
//  sys_clk        in   1           system clock; all logic on rising edge
//  sys_rst        in   1           synchronous, active-high reset
//  note_valid     in   1           request present
//  note_ready     out  1           scheduler can accept request
//  note_on        in   1           1 = note-on, 0 = note-off
//  note_num       in   NOTE_W      note of request
//  tdm_slot       out  VOICE_BITS  current slot, to TDM_CHANNEL_NUM
//  tdm_slot_en    out  1           current slot's voice active, to TDM_CHANNEL_IS_EN
//  tdm_slot_note  out  NOTE_W      current slot's note (0 when inactive)
//  frame_start    out  1           high while tdm_slot == 0
//  active_count   out  VOICE_BITS+1  number of active voices
// BEHAVIOUR
//  Reset: slot=0, all voices inactive, note=0, age=0, FSM=IDLE, note_ready=0, outputs 0. Pending request dropped.
//  Slot counter: +1 every cycle, NUM_VOICES-1 -> 0. Never stalls.
//  tdm_* outputs are registered and reflect the table for the slot they carry.
//  Handshake: transfer when note_valid && note_ready. note_ready = (state==IDLE) && !sys_rst.
//  A transfer captures note_on/note_num and moves the FSM IDLE -> SCAN.
//  SCAN: examines one voice per cycle, index 0..NUM_VOICES-1 (exactly NUM_VOICES cycles), recording:
//   match = lowest active voice with note==note_num;
//   free  = lowest inactive voice;
//   oldest = active voice with max age, ties to lowest index.
//  After the last index: -> WAIT_FRAME.
//  WAIT_FRAME: held until tdm_slot==NUM_VOICES-1. Commit occurs on that edge, so the change is
//   visible from slot 0 of the next frame. Frames are never torn. Then -> IDLE.
//  Commit on note-on, target chosen as match, else free, else oldest (steal):
//   target gets active=1, note=note_num, age=0;
//   every other active voice gets age+1, saturating at 2^AGE_W-1.
//  Commit on note-off: match, if any, gets active=0 and note=0. No match -> no-op. Ages unchanged.
//  Duplicate note-on retriggers the matching voice and does not consume a second voice.
//  Request latency: handshake to table update = NUM_VOICES + 1 .. 2*NUM_VOICES cycles.
//  active_count is registered and updated on the commit edge.
//  sys_rst asserted in any state overrides everything in that cycle.
// STRUCTURE
//  Shared package tdm_pkg holds:
//   FSM state typedef (IDLE, SCAN, WAIT_FRAME);
//   NUM_VOICES, VOICE_BITS, NOTE_W, AGE_W constants;
//   voice entry struct {active, note, age}.
//  One sub-module, tdm_slot_counter: wrap counter plus frame_start and last_slot flags.
//   Shared with other TDM stages.
//  Table, scan registers and FSM live in this module.
// TESTING
//  1 Reset release, no requests: tdm_slot cycles 0,1,2,3,0; frame_start every 4th cycle;
//    tdm_slot_en=0; note_ready=1 from first post-reset cycle.
//  2 Note-on 60 then 64: voice0 note60, voice1 note64. tdm_slot_en=1 at slots 0,1 only.
//    active_count=2. Each update first seen at a slot 0.
//  3 Note-on 60,62,64,65, then 67: all voices busy, so voice0 (oldest, age 3) becomes 67.
//    Other ages increment.
//  4 Note-on 60 twice: single voice used, active_count=1, voice0 age reset to 0.
//    Note-off 61 afterwards: no change.
//  5 Note-off 62 with 60,62,64 active: voice1 cleared. A later note-on 70 reuses voice1.
//  6 sys_rst pulsed during WAIT_FRAME with note-on pending: table empty, no commit,
//    note_ready=0 in the reset cycle and 1 the cycle after.
//  Throughout: note_valid held without note_ready must not be accepted twice.

Source files
------------

// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared TDM constants, scheduler state encoding and voice entry type
package tdm_pkg;

    localparam int NUM_VOICES = 4;
    localparam int VOICE_BITS = 2;
    localparam int NOTE_W     = 7;
    localparam int AGE_W      = 4;

    localparam logic [VOICE_BITS-1:0] LAST_SLOT = VOICE_BITS'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0]      AGE_MAX   = {AGE_W{1'b1}};

    typedef logic [1:0] tdm_state_t;
    localparam tdm_state_t ST_IDLE       = 2'd0;
    localparam tdm_state_t ST_SCAN       = 2'd1;
    localparam tdm_state_t ST_WAIT_FRAME = 2'd2;

    typedef struct packed {
        logic              active;
        logic [NOTE_W-1:0] note;
        logic [AGE_W-1:0]  age;
    } voice_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - free-running TDM slot counter with frame_start and last_slot flags
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    output logic [VOICE_BITS-1:0] slot,
    output logic                  frame_start,
    output logic                  last_slot
);

    // NUM_VOICES is a power of two, so the natural wrap gives NUM_VOICES-1 -> 0.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            slot <= '0;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    assign frame_start = (slot == '0);
    assign last_slot   = (slot == LAST_SLOT);

endmodule

// File: rtl/tdm_voice_scheduler.sv
// rtl/tdm_voice_scheduler.sv - voice table, note request allocator and TDM slot sequencer
module tdm_voice_scheduler
    import tdm_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  note_valid,
    output logic                  note_ready,
    input  logic                  note_on,
    input  logic [NOTE_W-1:0]     note_num,
    output logic [VOICE_BITS-1:0] tdm_slot,
    output logic                  tdm_slot_en,
    output logic [NOTE_W-1:0]     tdm_slot_note,
    output logic                  frame_start,
    output logic [VOICE_BITS:0]   active_count
);

    voice_t                  voices   [NUM_VOICES];
    voice_t                  voices_d [NUM_VOICES];
    voice_t                  scan_voice;
    tdm_state_t              state;
    logic                    last_slot;
    logic [VOICE_BITS-1:0]   slot_next;
    logic [VOICE_BITS-1:0]   scan_idx;
    logic                    req_on;
    logic [NOTE_W-1:0]       req_note;
    logic                    match_found;
    logic [VOICE_BITS-1:0]   match_idx;
    logic                    free_found;
    logic [VOICE_BITS-1:0]   free_idx;
    logic                    oldest_found;
    logic [VOICE_BITS-1:0]   oldest_idx;
    logic [AGE_W-1:0]        oldest_age;
    logic [VOICE_BITS-1:0]   target;
    logic                    commit;
    logic [VOICE_BITS:0]     count_d;

    tdm_slot_counter u_slot_counter (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .slot        (tdm_slot),
        .frame_start (frame_start),
        .last_slot   (last_slot)
    );

    assign note_ready = (state == ST_IDLE) && !sys_rst;
    assign slot_next  = tdm_slot + 1'b1;
    assign scan_voice = voices[scan_idx];
    assign commit     = (state == ST_WAIT_FRAME) && last_slot;
    assign target     = match_found ? match_idx : (free_found ? free_idx : oldest_idx);

    // Next table: only the commit edge (last slot of a frame) ever changes it.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            voices_d[i] = voices[i];
        end
        if (commit) begin
            if (req_on) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (VOICE_BITS'(i) == target) begin
                        voices_d[i].active = 1'b1;
                        voices_d[i].note   = req_note;
                        voices_d[i].age    = '0;
                    end else if (voices[i].active && voices[i].age != AGE_MAX) begin
                        voices_d[i].age = voices[i].age + 1'b1;
                    end
                end
            end else if (match_found) begin
                voices_d[match_idx].active = 1'b0;
                voices_d[match_idx].note   = '0;
            end
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            count_d = count_d + (VOICE_BITS+1)'(voices_d[i].active);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                voices[i] <= '0;
            end
            state         <= ST_IDLE;
            scan_idx      <= '0;
            req_on        <= 1'b0;
            req_note      <= '0;
            match_found   <= 1'b0;
            match_idx     <= '0;
            free_found    <= 1'b0;
            free_idx      <= '0;
            oldest_found  <= 1'b0;
            oldest_idx    <= '0;
            oldest_age    <= '0;
            tdm_slot_en   <= 1'b0;
            tdm_slot_note <= '0;
            active_count  <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                voices[i] <= voices_d[i];
            end
            // Outputs are looked up for the slot the counter moves to on this edge.
            tdm_slot_en   <= voices_d[slot_next].active;
            tdm_slot_note <= voices_d[slot_next].active ? voices_d[slot_next].note : '0;
            active_count  <= count_d;

            case (state)
                ST_IDLE: begin
                    if (note_valid) begin
                        req_on       <= note_on;
                        req_note     <= note_num;
                        scan_idx     <= '0;
                        match_found  <= 1'b0;
                        free_found   <= 1'b0;
                        oldest_found <= 1'b0;
                        state        <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_voice.active && scan_voice.note == req_note && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!scan_voice.active && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    // Strict compare keeps the lowest index among equal ages.
                    if (scan_voice.active && (!oldest_found || scan_voice.age > oldest_age)) begin
                        oldest_found <= 1'b1;
                        oldest_idx   <= scan_idx;
                        oldest_age   <= scan_voice.age;
                    end
                    if (scan_idx == LAST_SLOT) begin
                        state <= ST_WAIT_FRAME;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (last_slot) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
